// File: rtl/accum_table_ctrl_if.sv
// Command/strobe bundle between the tile scheduler (master) and the accumulator-table sequencer (slave).
interface accum_table_ctrl_if #(
  parameter int AW   = 10,
  parameter int COLS = 16
);
  logic                 start_accum;
  logic                 start_read;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          num_rows;
  logic                 ready;
  logic                 done;
  logic                 rd_valid;
  logic [COLS-1:0]      clear;
  logic [COLS-1:0]      rd_en;
  logic [COLS-1:0]      wr_en;
  logic [AW*COLS-1:0]   rd_addr;
  logic [AW*COLS-1:0]   wr_addr;

  modport master (
    output start_accum, start_read, base_addr, num_rows,
    input  ready, done, rd_valid, clear, rd_en, wr_en, rd_addr, wr_addr
  );

  modport slave (
    input  start_accum, start_read, base_addr, num_rows,
    output ready, done, rd_valid, clear, rd_en, wr_en, rd_addr, wr_addr
  );
endinterface

// File: rtl/accum_table_ctrl.sv
// Accumulator-table sequencer: one-shot accumulate/read commands become per-column table strobes.
// Optional macro ACCUM_CLEAR_AFTER_READ_EN adds a one-cycle all-column clear after every read pass.
module accum_table_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16
) (
  input logic               clk,
  input logic               reset,
  accum_table_ctrl_if.slave bus
);
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int AW             = $clog2(NUM_ACCUM_ROWS);
  localparam int CW             = (SYS_ARR_COLS > 2) ? $clog2(SYS_ARR_COLS) : 1;
  localparam logic [AW:0]   ROWS_MAX  = (AW+1)'(NUM_ACCUM_ROWS);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_ACCUM_ROWS - 1);
  localparam logic [CW-1:0] SKEW_LAST = CW'((SYS_ARR_COLS > 1) ? (SYS_ARR_COLS - 2) : 0);

  // Data width and array height describe the surrounding datapath only; the skew needs two columns.
  if (DATA_WIDTH < 1 || SYS_ARR_ROWS < 1 || SYS_ARR_COLS < 2) begin : g_bad_cfg
    $error("accum_table_ctrl: unsupported configuration");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_SKEW  = 3'd2,
    S_READ  = 3'd3,
`ifdef ACCUM_CLEAR_AFTER_READ_EN
    S_RTAIL = 3'd4,
    S_CLR   = 3'd5
`else
    S_RTAIL = 3'd4
`endif
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_rd_valid;
  logic [SYS_ARR_COLS-1:0] r_clear;
  logic                    r_rd_en;
  logic [AW-1:0]           r_rd_addr;
  logic [SYS_ARR_COLS-1:0] r_wr_en;
  logic [AW-1:0]           r_wr_addr [SYS_ARR_COLS];
  logic [AW:0]             r_remain;
  logic [AW-1:0]           r_next_addr;
  logic [CW-1:0]           r_skew_cnt;
  logic [AW:0]             w_rows_sat;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == ADDR_LAST) ? {AW{1'b0}} : (a + AW'(1'b1));
  endfunction

  // Clamp the requested row count to the table depth.
  always_comb begin
    if (bus.num_rows > ROWS_MAX) begin
      w_rows_sat = ROWS_MAX;
    end else begin
      w_rows_sat = bus.num_rows;
    end
  end

  // Pass sequencer; column 0 is driven here and columns 1..N-1 are a pure delay line behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_clear     <= {SYS_ARR_COLS{1'b0}};
      r_rd_en     <= 1'b0;
      r_rd_addr   <= {AW{1'b0}};
      r_wr_en     <= {SYS_ARR_COLS{1'b0}};
      r_remain    <= {(AW+1){1'b0}};
      r_next_addr <= {AW{1'b0}};
      r_skew_cnt  <= {CW{1'b0}};
      for (int c = 0; c < SYS_ARR_COLS; c++) begin
        r_wr_addr[c] <= {AW{1'b0}};
      end
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= r_rd_en;
      for (int c = 1; c < SYS_ARR_COLS; c++) begin
        r_wr_en[c]   <= r_wr_en[c-1];
        r_wr_addr[c] <= r_wr_addr[c-1];
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start_accum) begin
            if (w_rows_sat == {(AW+1){1'b0}}) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= S_ACCUM;
              r_ready      <= 1'b0;
              r_wr_en[0]   <= 1'b1;
              r_wr_addr[0] <= bus.base_addr;
              r_remain     <= w_rows_sat - (AW+1)'(1'b1);
              r_next_addr  <= addr_inc(bus.base_addr);
            end
          end else if (bus.start_read) begin
            if (w_rows_sat == {(AW+1){1'b0}}) begin
`ifdef ACCUM_CLEAR_AFTER_READ_EN
              r_state <= S_CLR;
              r_ready <= 1'b0;
              r_clear <= {SYS_ARR_COLS{1'b1}};
`else
              r_done  <= 1'b1;
`endif
            end else begin
              r_state     <= S_READ;
              r_ready     <= 1'b0;
              r_rd_en     <= 1'b1;
              r_rd_addr   <= bus.base_addr;
              r_remain    <= w_rows_sat - (AW+1)'(1'b1);
              r_next_addr <= addr_inc(bus.base_addr);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCUM: begin
          if (r_remain != {(AW+1){1'b0}}) begin
            r_wr_en[0]   <= 1'b1;
            r_wr_addr[0] <= r_next_addr;
            r_next_addr  <= addr_inc(r_next_addr);
            r_remain     <= r_remain - (AW+1)'(1'b1);
          end else begin
            r_wr_en[0] <= 1'b0;
            r_state    <= S_SKEW;
            r_skew_cnt <= SKEW_LAST;
          end
        end
        S_SKEW: begin
          // Wait for the last column's delayed strobe to drain before reporting done.
          if (r_skew_cnt == {CW{1'b0}}) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_skew_cnt <= r_skew_cnt - CW'(1'b1);
          end
        end
        S_READ: begin
          if (r_remain != {(AW+1){1'b0}}) begin
            r_rd_en     <= 1'b1;
            r_rd_addr   <= r_next_addr;
            r_next_addr <= addr_inc(r_next_addr);
            r_remain    <= r_remain - (AW+1)'(1'b1);
          end else begin
            r_rd_en <= 1'b0;
            r_state <= S_RTAIL;
          end
        end
        S_RTAIL: begin
`ifdef ACCUM_CLEAR_AFTER_READ_EN
          r_state <= S_CLR;
          r_clear <= {SYS_ARR_COLS{1'b1}};
`else
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
`endif
        end
`ifdef ACCUM_CLEAR_AFTER_READ_EN
        S_CLR: begin
          r_clear <= {SYS_ARR_COLS{1'b0}};
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b1;
          r_rd_en    <= 1'b0;
          r_wr_en[0] <= 1'b0;
          r_clear    <= {SYS_ARR_COLS{1'b0}};
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.rd_valid = r_rd_valid;
  assign bus.clear    = r_clear;
  assign bus.rd_en    = {SYS_ARR_COLS{r_rd_en}};
  assign bus.wr_en    = r_wr_en;

  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_addr
    assign bus.rd_addr[c*AW +: AW] = r_rd_addr;
    assign bus.wr_addr[c*AW +: AW] = r_wr_addr[c];
  end
endmodule

// File: tb/tb_accum_table_ctrl.sv
// Randomized bench for accum_table_ctrl (4 columns, 32-row table) against a per-pass timeline model.
module tb_accum_table_ctrl;
  localparam int COLS = 4;
  localparam int NUM  = 32;
  localparam int AW   = 5;

  logic clk;
  logic reset;

  accum_table_ctrl_if #(.AW(AW), .COLS(COLS)) bus();

  accum_table_ctrl #(
    .DATA_WIDTH(16), .MAX_OUT_ROWS(8), .MAX_OUT_COLS(16), .SYS_ARR_ROWS(16), .SYS_ARR_COLS(COLS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sa;
    bit sr;
    int base;
    int n;
    int rst_off;
    int tag;
  } req_t;

  req_t reqs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Cycle (relative to the start cycle) at which a pass reports done.
  function automatic int pass_end(input int kind, input int n);
    if (kind == 0) return (n == 0) ? 1 : n + COLS;
`ifdef ACCUM_CLEAR_AFTER_READ_EN
    return (n == 0) ? 2 : n + 3;
`else
    return (n == 0) ? 1 : n + 2;
`endif
  endfunction

  function automatic void add_req(input bit sa, input bit sr, input int base, input int n,
                                  input int rst_off, input int tag);
    req_t r;
    r.sa = sa; r.sr = sr; r.base = base; r.n = n; r.rst_off = rst_off; r.tag = tag;
    reqs.push_back(r);
  endfunction

  initial begin
    int cur, t, e_end, gap, wr0_cnt, clr_cyc;
    int p_start, p_kind, p_base, p_n, p_tag, p_rst;
    bit p_act;
    logic       e_ready, e_done, e_rv;
    logic [COLS-1:0] e_clr, e_rd, e_wr;
    int e_raddr;
    int e_waddr [COLS];
    req_t r;

    cur = 0; gap = 2; wr0_cnt = 0; p_act = 1'b0;
    p_start = 0; p_kind = 0; p_base = 0; p_n = 0; p_tag = 0; p_rst = 0;

    add_req(1'b1, 1'b0, 5, 3, 0, 1);
    add_req(1'b0, 1'b1, 30, 4, 0, 2);
    add_req(1'b1, 1'b1, 10, 2, 0, 3);
    add_req(1'b1, 1'b0, 9, 0, 0, 6);
    add_req(1'b0, 1'b1, 9, 0, 0, 7);
    add_req(1'b1, 1'b0, 7, 40, 0, 4);
    add_req(1'b1, 1'b0, 2, 8, 3, 5);
    add_req(1'b1, 1'b0, 0, 5, 0, 0);
    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 2);
      add_req(k != 1, k != 0, $urandom_range(0, NUM-1),
              ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 12),
              ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0, 0);
    end

    reset = 1'b1;
    bus.start_accum = 1'b0;
    bus.start_read  = 1'b0;
    bus.base_addr   = '0;
    bus.num_rows    = '0;

    while (1'b1) begin
      @(negedge clk);
      cur++;

      // Expected outputs for this cycle from the active pass timeline.
      e_ready = 1'b1; e_done = 1'b0; e_rv = 1'b0;
      e_clr = '0; e_rd = '0; e_wr = '0; e_raddr = 0;
      t = 0; e_end = 0;
      for (int c = 0; c < COLS; c++) e_waddr[c] = 0;
      if (p_act) begin
        t = cur - p_start;
        e_end = pass_end(p_kind, p_n);
        if (t >= 1 && t < e_end) e_ready = 1'b0;
        if (t == e_end) e_done = 1'b1;
        if (p_kind == 0) begin
          for (int c = 0; c < COLS; c++) begin
            if (t >= 1 + c && t <= p_n + c) begin
              e_wr[c] = 1'b1;
              e_waddr[c] = (p_base + t - 1 - c) % NUM;
            end
          end
        end else begin
          if (t >= 1 && t <= p_n) begin
            e_rd = '1;
            e_raddr = (p_base + t - 1) % NUM;
          end
          if (t >= 2 && t <= p_n + 1) e_rv = 1'b1;
`ifdef ACCUM_CLEAR_AFTER_READ_EN
          clr_cyc = (p_n == 0) ? 1 : p_n + 2;
          if (t == clr_cyc) e_clr = '1;
`else
          clr_cyc = -1;
`endif
        end
      end

      chk("ready", cur, 64'(bus.ready), 64'(e_ready));
      chk("done", cur, 64'(bus.done), 64'(e_done));
      chk("rd_valid", cur, 64'(bus.rd_valid), 64'(e_rv));
      chk("clear", cur, 64'(bus.clear), 64'(e_clr));
      chk("rd_en", cur, 64'(bus.rd_en), 64'(e_rd));
      chk("wr_en", cur, 64'(bus.wr_en), 64'(e_wr));
      for (int c = 0; c < COLS; c++) begin
        if (e_rd[c]) chk("rd_addr", cur, 64'(bus.rd_addr[c*AW +: AW]), 64'(e_raddr));
        if (e_wr[c]) chk("wr_addr", cur, 64'(bus.wr_addr[c*AW +: AW]), 64'(e_waddr[c]));
      end

      // Hand-computed expectations for the directed passes.
      if (p_act) begin
        if (p_tag == 1 && t == 1) chk("t1_col0_first_addr", cur, 64'(bus.wr_addr[0 +: AW]), 64'd5);
        if (p_tag == 1 && t == 6) chk("t1_col3_last_addr", cur, 64'(bus.wr_addr[3*AW +: AW]), 64'd7);
        if (p_tag == 1 && t == 7) chk("t1_done", cur, 64'(bus.done), 64'd1);
        if (p_tag == 2 && t == 3) chk("t2_wrap_addr", cur, 64'(bus.rd_addr[AW +: AW]), 64'd0);
        if (p_tag == 2 && t == 5) chk("t2_rd_valid_last", cur, 64'(bus.rd_valid), 64'd1);
`ifdef ACCUM_CLEAR_AFTER_READ_EN
        if (p_tag == 2 && t == 6) chk("t2_clear", cur, 64'(bus.clear), 64'hF);
        if (p_tag == 2 && t == 7) chk("t2_done", cur, 64'(bus.done), 64'd1);
`else
        if (p_tag == 2 && t == 6) chk("t2_done", cur, 64'(bus.done), 64'd1);
`endif
        if (p_tag == 3 && t == 1) chk("t3_no_read", cur, 64'(bus.rd_en), 64'd0);
        if (p_tag == 6 && t == 1) chk("t4_zero_done", cur, 64'(bus.done), 64'd1);
        if (p_tag == 5 && t == 4) chk("t5_after_reset", cur, 64'({bus.ready, bus.wr_en}), 64'h10);
        if (p_tag == 4 && bus.wr_en[0] === 1'b1) wr0_cnt++;
        if (p_tag == 4 && t == e_end) chk("t4_sat_wr0_cycles", cur, 64'(wr0_cnt), 64'd32);
      end

      if (p_act && t >= e_end) p_act = 1'b0;
      if (!p_act && gap == 0 && reqs.size() == 0) break;
      if (cur > 20000) begin
        total++;
        bad++;
        $display("FAIL cycle_budget cyc=%0d limit=20000", cur);
        break;
      end

      // Drive this cycle's inputs; they are sampled at the next rising edge.
      reset = (cur < 3) ? 1'b1 : 1'b0;
      bus.start_accum = 1'b0;
      bus.start_read  = 1'b0;
      bus.base_addr   = AW'($urandom_range(0, NUM-1));
      bus.num_rows    = (AW+1)'($urandom_range(0, 63));
      if (cur < 3) begin
        gap = 2;
      end else if (p_act) begin
        if (p_rst != 0 && t == p_rst) begin
          reset = 1'b1;
          bus.start_accum = 1'($urandom_range(0, 1));
          p_act = 1'b0;
          gap = 1;
        end else if ($urandom_range(0, 5) == 0) begin
          bus.start_accum = 1'($urandom_range(0, 1));
          bus.start_read  = 1'($urandom_range(0, 1));
        end
      end else if (gap > 0) begin
        gap--;
      end else if (reqs.size() > 0) begin
        r = reqs.pop_front();
        bus.start_accum = r.sa;
        bus.start_read  = r.sr;
        bus.base_addr   = AW'(r.base);
        bus.num_rows    = (AW+1)'(r.n);
        p_act   = 1'b1;
        p_start = cur;
        p_kind  = r.sa ? 0 : 1;
        p_base  = r.base;
        p_n     = (r.n > NUM) ? NUM : r.n;
        p_tag   = r.tag;
        p_rst   = r.rst_off;
        wr0_cnt = 0;
        gap     = $urandom_range(0, 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
